// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
//   Shared definitions for the fetch sequencer: default address width, reset
//   and trap vectors, and the FSM state encoding.
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

   localparam int unsigned       DEF_ADDR_W    = 16;
   localparam logic [15:0]       DEF_RESET_VEC = 16'h0000;
   localparam logic [15:0]       DEF_TRAP_VEC  = 16'h0010;

   // IDLE  : one cycle after reset before the first fetch
   // FETCH : request outstanding, waiting for imem_ack
   // GAP   : mandatory bubble after every accepted fetch
   // STALL : downstream not ready, no new fetch issued
   // HALT  : fetching stopped until reset
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_GAP   = 3'd2,
      ST_STALL = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

endpackage : pc_sequencer_pkg

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
//   Bundles the instruction-memory handshake, the control inputs from the
//   pipeline and the delivered-instruction outputs of the fetch sequencer.
//
//   master : the sequencer itself
//            out imem_req, imem_addr, inst_valid, inst, inst_pc, halted
//            in  imem_ack, imem_rdata, stall, redirect_valid,
//                redirect_target, trap, halt
//   slave  : the environment (memory + pipeline), directions reversed
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
   parameter int ADDR_W = 16
);

   // instruction-memory handshake
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [ADDR_W-1:0] imem_rdata;

   // pipeline control
   logic              stall;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_target;
   logic              trap;
   logic              halt;

   // delivery to decode
   logic              inst_valid;
   logic [ADDR_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;
   logic              halted;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc, halted,
      input  imem_ack, imem_rdata, stall, redirect_valid, redirect_target,
             trap, halt
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc, halted,
      output imem_ack, imem_rdata, stall, redirect_valid, redirect_target,
             trap, halt
   );

endinterface : pc_sequencer_if

// File: rtl/pc_sequencer_pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
//   Combinational next-PC priority select:
//      trap > redirect > pending (squashed) target > pc+1 > pc
//   pc+1 wraps naturally at the top of the address space.
//
//   trap, redirect_valid, redirect_target : same-cycle control events
//   use_pend, pend_pc                     : target captured earlier in a fetch
//   advance                               : increment pc when nothing overrides
//   pc                                    : current program counter
//   next_pc                               : selected PC
//   event_hit / event_pc                  : a same-cycle event and its target
// -----------------------------------------------------------------------------
module pc_next_sel #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] TRAP_VEC = '0
) (
   input  logic              trap,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              use_pend,
   input  logic [ADDR_W-1:0] pend_pc,
   input  logic              advance,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] next_pc,
   output logic              event_hit,
   output logic [ADDR_W-1:0] event_pc
);

   always_comb begin
      event_hit = trap | redirect_valid;
      event_pc  = trap ? TRAP_VEC : redirect_target;

      if (event_hit) begin
         next_pc = event_pc;
      end else if (use_pend) begin
         next_pc = pend_pc;
      end else if (advance) begin
         next_pc = pc + ADDR_W'(1);
      end else begin
         next_pc = pc;
      end
   end

endmodule : pc_next_sel

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Fetch sequencer owning the word-addressed program counter. Issues one
//   instruction-memory request at a time, delivers the fetched word with its
//   PC, and applies stall / redirect / trap / halt to choose the next PC.
//
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : pc_sequencer_if.master (memory handshake, control, delivery)
//
//   Every accepted fetch is followed by a one-cycle GAP, giving one
//   instruction per two cycles with a zero-wait memory. Redirects that arrive
//   while a request is outstanding cannot move imem_addr, so they are parked
//   in pend_pc and the in-flight data is squashed when it returns.
// -----------------------------------------------------------------------------
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC,
   parameter logic [ADDR_W-1:0] TRAP_VEC  = DEF_TRAP_VEC
) (
   input logic            clk,
   input logic            rst,
   pc_sequencer_if.master bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic              squash_q, squash_d;
   logic              halt_pend_q, halt_pend_d;
   logic              imem_req_q, imem_req_d;
   logic              inst_valid_q, inst_valid_d;
   logic [ADDR_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
   logic              halted_q, halted_d;

   logic [ADDR_W-1:0] next_pc;
   logic              event_hit;
   logic [ADDR_W-1:0] event_pc;
   logic              in_fetch;

   assign in_fetch = (state_q == ST_FETCH);

   // squash_q is only ever set inside FETCH and cleared on leaving it, so
   // outside FETCH the selector falls through to "hold pc" unless an event
   // arrives.
   pc_next_sel #(
      .ADDR_W   (ADDR_W),
      .TRAP_VEC (TRAP_VEC)
   ) u_pc_next_sel (
      .trap            (bus.trap),
      .redirect_valid  (bus.redirect_valid),
      .redirect_target (bus.redirect_target),
      .use_pend        (squash_q),
      .pend_pc         (pend_pc_q),
      .advance         (in_fetch),
      .pc              (pc_q),
      .next_pc         (next_pc),
      .event_hit       (event_hit),
      .event_pc        (event_pc)
   );

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
   // pre-edge values of the others; blocking here would create order-dependent
   // simulation that no longer matches the synthesised hardware.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: each combinational block assigns every output a default first, so
   // no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  state_d = bus.halt ? ST_HALT : ST_FETCH;
         ST_FETCH: if (bus.imem_ack) state_d = ST_GAP;
         ST_GAP: begin
            if (halt_pend_q || bus.halt) state_d = ST_HALT;
            else if (bus.stall)          state_d = ST_STALL;
            else                         state_d = ST_FETCH;
         end
         ST_STALL: begin
            if (bus.halt)       state_d = ST_HALT;
            else if (!bus.stall) state_d = ST_FETCH;
         end
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath next-values: PC, pending target, squash, delivery
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_d         = pc_q;
      pend_pc_d    = pend_pc_q;
      squash_d     = squash_q;
      halt_pend_d  = halt_pend_q;
      inst_valid_d = 1'b0;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;

      unique case (state_q)
         ST_FETCH: begin
            halt_pend_d = halt_pend_q | bus.halt;
            if (bus.imem_ack) begin
               // next_pc already prefers a same-cycle event, then pend_pc,
               // then pc+1; data is delivered only when nothing redirected.
               pc_d     = next_pc;
               squash_d = 1'b0;
               if (!event_hit && !squash_q) begin
                  inst_valid_d = 1'b1;
                  inst_d       = bus.imem_rdata;
                  inst_pc_d    = pc_q;
               end
            end else if (event_hit) begin
               // Address must stay stable, so park the target for the ack.
               squash_d  = 1'b1;
               pend_pc_d = event_pc;
            end
         end
         ST_GAP, ST_STALL: begin
            pc_d = next_pc;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic: registered Moore outputs derived from the next state
   // ---------------------------------------------------------------------------
   always_comb begin
      imem_req_d = (state_d == ST_FETCH);
      halted_d   = (state_d == ST_HALT);
   end

   // ---------------------------------------------------------------------------
   // Datapath and output registers
   // ---------------------------------------------------------------------------
   // NOTE: all flops here are plain registers, so every one of them is reset;
   // there is no storage array whose contents could be left unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_VEC;
         pend_pc_q    <= RESET_VEC;
         squash_q     <= 1'b0;
         halt_pend_q  <= 1'b0;
         imem_req_q   <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         halted_q     <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         pend_pc_q    <= pend_pc_d;
         squash_q     <= squash_d;
         halt_pend_q  <= halt_pend_d;
         imem_req_q   <= imem_req_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         halted_q     <= halted_d;
      end
   end

   // pc only moves outside FETCH, so it doubles as the stable fetch address.
   assign bus.imem_addr  = pc_q;
   assign bus.imem_req   = imem_req_q;
   assign bus.inst_valid = inst_valid_q;
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.halted     = halted_q;

endmodule : pc_sequencer
